// File: rtl/sevenseg_pkg.sv
// Shared glyph constants and helpers for the multiplexed seven-segment driver.
// All glyphs are active-low, bit0 = segment a ... bit6 = segment g.
package sevenseg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Power-up buffer contents: "SAFE" right-aligned, repeating leftwards when
  // the display has more than four digits (digit 0 is the rightmost).
  function automatic logic [MAX_DIGITS*7-1:0] safe_pattern(input int n);
    logic [MAX_DIGITS*7-1:0] pat;
    pat = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) begin
        case (i % 4)
          0:       pat[i*7 +: 7] = SEG_E;
          1:       pat[i*7 +: 7] = SEG_F;
          2:       pat[i*7 +: 7] = SEG_A;
          default: pat[i*7 +: 7] = SEG_S;
        endcase
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/sevenseg_prescaler.sv
// Scan-slot prescaler: produces a one-cycle enable every DIV clocks while
// start is high. It is an enable, not a derived clock.
module sevenseg_prescaler
  import sevenseg_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_at_top;

  assign w_at_top = (r_pcnt == TOP);
  assign tick     = start & w_at_top;

  // Free-running 0..DIV-1 counter, parked at zero while scanning is off.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pcnt <= '0;
    end else if (!start) begin
      r_pcnt <= '0;
    end else if (w_at_top) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment driver. Scans digits left to right,
// optionally followed by an all-off guard slot, with per-digit blinking and
// frame-aligned buffer swaps so the host never causes a torn frame.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIV          = 100000,
  parameter int BLANK_SLOT   = 1,
  parameter int BLINK_FRAMES = 50,
  parameter logic [DIGITS*7-1:0] RESET_PATTERN = (DIGITS*7)'(safe_pattern(DIGITS))
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIGITS*7-1:0]   digits_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int NSLOTS = DIGITS + BLANK_SLOT;
  localparam int SW     = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOTS - 1);
  localparam logic [BW-1:0] LAST_BCNT = BW'(BLINK_FRAMES - 1);

  logic [SW-1:0]          r_slot;
  logic [DIGITS*7-1:0]    r_pending;
  logic [DIGITS*7-1:0]    r_active;
  logic [BW-1:0]          r_bcnt;
  logic                   r_bph;
  logic [DIGITS-1:0]      r_an;
  logic [6:0]             r_seg;
  logic                   r_frame_done;

  logic                   w_tick;
  logic                   w_wrap;
  logic [DIGITS-1:0]      w_an_nxt;
  logic [6:0]             w_seg_nxt;

  sevenseg_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .tick    (w_tick)
  );

  assign w_wrap     = w_tick & (r_slot == LAST_SLOT);
  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  // Decode the current slot into anode/segment values; the guard slot and a
  // blinked-off digit both fall through to the all-off default.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_slot == SW'(DIGITS - 1 - i)) begin
        if (!(blink_mask[i] && r_bph)) begin
          w_an_nxt[i] = 1'b0;
          w_seg_nxt   = r_active[i*7 +: 7];
        end
      end
    end
  end

  // Slot counter: restarts at the leftmost digit whenever scanning stops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else if (!start) begin
      r_slot <= '0;
    end else if (w_tick) begin
      r_slot <= w_wrap ? '0 : r_slot + SW'(1);
    end
  end

  // Registered display outputs, updated only on slot ticks.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (!start) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (w_tick) begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  // Double buffer: host writes land in pending and are promoted at the frame
  // wrap; a load on the wrap edge bypasses pending so it is not lost a frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pending <= RESET_PATTERN;
      r_active  <= RESET_PATTERN;
    end else begin
      if (load) begin
        r_pending <= digits_in;
      end
      if (w_wrap) begin
        r_active <= load ? digits_in : r_pending;
      end
    end
  end

  // Blink phase: toggles every BLINK_FRAMES completed frames; held while stopped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_bcnt <= '0;
      r_bph  <= 1'b0;
    end else if (w_wrap) begin
      if (r_bcnt == LAST_BCNT) begin
        r_bcnt <= '0;
        r_bph  <= ~r_bph;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  // Frame-complete pulse, one cycle after the wrap edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
    end
  end

endmodule
